// File: rtl/ram_sync_clr_if.sv
// Write/read/clear bus for ram_sync_clr; the master drives requests and the slave returns read data and busy.
interface ram_sync_clr_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  modport master (
    output clr, we, waddr, wdata, wmask, re, raddr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  clr, we, waddr, wdata, wmask, re, raddr,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/ram_sync_clr.sv
// Single-clock RAM with bit-masked writes, registered reads, selectable collision mode
// and a sweep sequencer that zeroes every entry after reset or on a clr request.
module ram_sync_clr #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned RD_MODE = 0
) (
  input logic           clk,
  input logic           rst,
  ram_sync_clr_if.slave bus
);
  localparam int unsigned     IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic              w_busy;
  logic              w_waddr_ok;
  logic              w_raddr_ok;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_collide;
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;
  logic [IDX_W-1:0]  w_cidx;
  logic [DATA_W-1:0] w_wr_word;
  logic [DATA_W-1:0] w_rd_word;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_CLEAR;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == LAST) w_next = S_IDLE;
      S_IDLE:  if (bus.clr)       w_next = S_CLEAR;
      default: w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst)                         r_cnt <= '0;
    else if (w_busy && r_cnt != LAST) r_cnt <= r_cnt + ADDR_W'(1);
    else                              r_cnt <= '0;
  end

  always_comb begin
    w_waddr_ok = (32'(bus.waddr) < DEPTH);
    w_raddr_ok = (32'(bus.raddr) < DEPTH);
    w_widx     = bus.waddr[IDX_W-1:0];
    w_ridx     = bus.raddr[IDX_W-1:0];
    w_cidx     = r_cnt[IDX_W-1:0];
    w_wr_en    = bus.we && !w_busy && w_waddr_ok;
    w_rd_en    = bus.re && !w_busy;
    w_collide  = w_wr_en && w_rd_en && (bus.waddr == bus.raddr);
  end

  always_comb begin
    w_wr_word = '0;
    if (w_waddr_ok) w_wr_word = (r_mem[w_widx] & ~bus.wmask) | (bus.wdata & bus.wmask);
  end

  // Write-first forwards the merged word; read-first keeps the array's pre-edge value.
  always_comb begin
    w_rd_word = '0;
    if (w_raddr_ok) w_rd_word = r_mem[w_ridx];
    if (RD_MODE == 1 && w_collide) w_rd_word = w_wr_word;
  end

  // The array is left untouched on reset edges; the sweep clears it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_busy)       r_mem[w_cidx] <= '0;
      else if (w_wr_en) r_mem[w_widx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_en;
      if (w_rd_en) r_rdata <= w_rd_word;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = w_busy;
endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench: dut0 read-first, dut1 write-first (both DEPTH 16), dut2 DEPTH 12; all share stimulus.
module tb_ram_sync_clr;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] wmask = '0;
  logic       re = 1'b0;
  logic [3:0] raddr = '0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sync_clr_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  ram_sync_clr_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
  ram_sync_clr_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

  always_comb begin
    if0.clr = clr; if0.we = we; if0.waddr = waddr; if0.wdata = wdata;
    if0.wmask = wmask; if0.re = re; if0.raddr = raddr;
    if1.clr = clr; if1.we = we; if1.waddr = waddr; if1.wdata = wdata;
    if1.wmask = wmask; if1.re = re; if1.raddr = raddr;
    if2.clr = clr; if2.we = we; if2.waddr = waddr; if2.wdata = wdata;
    if2.wmask = wmask; if2.re = re; if2.raddr = raddr;
  end

  ram_sync_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ram_sync_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  ram_sync_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_MODE(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    waddr = a; wdata = d; wmask = m; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    raddr = a; re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    int n0, n2;
    rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({if0.busy, if0.rvalid, if0.rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: busy/rvalid/rdata got %b/%b/%h want 1/0/00", if0.busy, if0.rvalid, if0.rdata);
    end
    rst = 1'b1;
    n0 = 0; n2 = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.busy) n0++;
      if (if2.busy) n2++;
      tick();
    end
    n_cmp++;
    if (n0 !== 16) begin
      n_err++; $display("FAIL sweep_len16: busy cycles got %0d want 16", n0);
    end
    n_cmp++;
    if (n2 !== 12) begin
      n_err++; $display("FAIL sweep_len12: busy cycles got %0d want 12", n2);
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      n_cmp++;
      if ({if0.rvalid, if0.rdata} !== {1'b1, 8'h00}) begin
        n_err++;
        $display("FAIL post_reset_rd[%0d]: rvalid/rdata got %b/%h want 1/00", a, if0.rvalid, if0.rdata);
      end
    end
    tick();
    n_cmp++;
    if (if0.rvalid !== 1'b0) begin
      n_err++; $display("FAIL rvalid_idle: got %b want 0", if0.rvalid);
    end
  endtask

  task automatic test_out_of_range();
    wr(4'd11, 8'h77, 8'hFF);
    wr(4'd13, 8'h5A, 8'hFF);
    rd(4'd11);
    n_cmp++;
    if (if2.rdata !== 8'h77) begin
      n_err++; $display("FAIL oor_inrange_wr: got %h want 77", if2.rdata);
    end
    rd(4'd13);
    n_cmp++;
    if ({if2.rvalid, if2.rdata} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL oor_rd13: rvalid/rdata got %b/%h want 1/00", if2.rvalid, if2.rdata);
    end
    n_cmp++;
    if (if0.rdata !== 8'h5A) begin
      n_err++; $display("FAIL depth16_rd13: got %h want 5a", if0.rdata);
    end
    for (int a = 0; a < 11; a++) begin
      rd(4'(a));
      n_cmp++;
      if (if2.rdata !== 8'h00) begin
        n_err++; $display("FAIL oor_untouched[%0d]: got %h want 00", a, if2.rdata);
      end
    end
  endtask

  task automatic test_masked_write();
    wr(4'd3, 8'hFF, 8'hFF);
    wr(4'd3, 8'h00, 8'h0F);
    rd(4'd3);
    n_cmp++;
    if ({if0.rvalid, if0.rdata} !== {1'b1, 8'hF0}) begin
      n_err++; $display("FAIL masked_rd: rvalid/rdata got %b/%h want 1/f0", if0.rvalid, if0.rdata);
    end
    tick();
    n_cmp++;
    if ({if0.rvalid, if0.rdata} !== {1'b0, 8'hF0}) begin
      n_err++; $display("FAIL masked_hold: rvalid/rdata got %b/%h want 0/f0", if0.rvalid, if0.rdata);
    end
    wr(4'd3, 8'h12, 8'h00);
    rd(4'd3);
    n_cmp++;
    if (if0.rdata !== 8'hF0) begin
      n_err++; $display("FAIL zero_mask: got %h want f0", if0.rdata);
    end
  endtask

  task automatic test_collision();
    wr(4'd5, 8'h11, 8'hFF);
    waddr = 4'd5; wdata = 8'h22; wmask = 8'hFF; we = 1'b1;
    raddr = 4'd5; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    n_cmp++;
    if (if0.rdata !== 8'h11) begin
      n_err++; $display("FAIL collide_rf: got %h want 11", if0.rdata);
    end
    n_cmp++;
    if (if1.rdata !== 8'h22) begin
      n_err++; $display("FAIL collide_wf: got %h want 22", if1.rdata);
    end
    rd(4'd5);
    n_cmp++;
    if ({if0.rdata, if1.rdata} !== {8'h22, 8'h22}) begin
      n_err++; $display("FAIL collide_after: rf/wf got %h/%h want 22/22", if0.rdata, if1.rdata);
    end
    waddr = 4'd5; wdata = 8'h0F; wmask = 8'hF0; we = 1'b1;
    raddr = 4'd5; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    n_cmp++;
    if ({if0.rdata, if1.rdata} !== {8'h22, 8'h02}) begin
      n_err++; $display("FAIL collide_masked: rf/wf got %h/%h want 22/02", if0.rdata, if1.rdata);
    end
  endtask

  task automatic test_clr_operation();
    int  n;
    logic bad;
    for (int a = 0; a < 16; a++) wr(4'(a), 8'hAA, 8'hFF);
    clr = 1'b1; re = 1'b1; raddr = 4'd7;
    tick();
    clr = 1'b0;
    n_cmp++;
    if ({if0.busy, if0.rvalid, if0.rdata} !== {1'b1, 1'b1, 8'hAA}) begin
      n_err++;
      $display("FAIL clr_edge_rd: busy/rvalid/rdata got %b/%b/%h want 1/1/aa", if0.busy, if0.rvalid, if0.rdata);
    end
    we = 1'b1; waddr = 4'd2; wdata = 8'h55; wmask = 8'hFF; raddr = 4'd2;
    n = 1; bad = 1'b0;
    tick();
    while (if0.busy && n < 30) begin
      n++;
      if (if0.rvalid !== 1'b0 || if0.rdata !== 8'hAA) bad = 1'b1;
      tick();
    end
    we = 1'b0; re = 1'b0;
    n_cmp++;
    if (n !== 16) begin
      n_err++; $display("FAIL clr_len: busy cycles got %0d want 16", n);
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL clr_quiet: rvalid or rdata changed while busy, got %b want 0", bad);
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      n_cmp++;
      if (if0.rdata !== 8'h00) begin
        n_err++; $display("FAIL clr_zero[%0d]: got %h want 00", a, if0.rdata);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    wr(4'd9, 8'h3C, 8'hFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({if0.busy, if0.rvalid} !== {1'b1, 1'b0}) begin
      n_err++; $display("FAIL midrst_state: busy/rvalid got %b/%b want 1/0", if0.busy, if0.rvalid);
    end
    rst = 1'b1;
    n = 0;
    while (if0.busy && n < 40) begin
      n++;
      clr = (n >= 3 && n <= 4);
      tick();
    end
    clr = 1'b0;
    n_cmp++;
    if (n !== 16) begin
      n_err++; $display("FAIL midrst_len: busy cycles got %0d want 16", n);
    end
    tick();
    n_cmp++;
    if (if0.busy !== 1'b0) begin
      n_err++; $display("FAIL clr_in_busy_ignored: busy got %b want 0", if0.busy);
    end
    rd(4'd9);
    n_cmp++;
    if (if0.rdata !== 8'h00) begin
      n_err++; $display("FAIL midrst_zero: got %h want 00", if0.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_masked_write();
    test_collision();
    test_clr_operation();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
